// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: double-buffered Game of Life grid, one cell per clock update, frame-aligned bank swap.
// Build macro LIFE_TORUS_EN wraps grid edges; without it off-grid neighbours read as dead.
module life_gen_scheduler #(
  parameter int unsigned GRID_W        = 16,
  parameter int unsigned GRID_H        = 16,
  parameter int unsigned PERIOD_FRAMES = 60,
  parameter int unsigned IDX_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             run,
  input  logic             step,
  input  logic             seed_req,
  input  logic             seed_valid,
  input  logic [IDX_W-1:0] seed_index,
  input  logic             seed_last,
  output logic             seed_ready,
  input  logic [IDX_W-1:0] disp_index,
  output logic             disp_cell,
  output logic             busy,
  output logic             gen_done,
  output logic [15:0]      gen_count
);

  localparam int unsigned N   = GRID_W * GRID_H;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FCW = 8;
  localparam int unsigned GCW = 16;
  localparam int          GW  = int'(GRID_W);
  localparam int          GH  = int'(GRID_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEED,
    S_COMPUTE,
    S_SWAP_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0][N-1:0]      bank_q, bank_d;
  logic                   front_sel_q, front_sel_d;
  logic [FCW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [GCW-1:0]         gen_count_q, gen_count_d;
  logic                   gen_done_q, gen_done_d;
  logic                   seed_pend_q, seed_pend_d;

  logic [N-1:0]           front_c;
  logic [3:0]             nbr_cnt_c;
  logic                   self_c;
  logic                   next_cell_c;
  logic                   trig_c;
  int                     cx_c, cy_c;

  // Neighbour lookup; coordinates may be one step off-grid.
  function automatic logic cell_at(input logic [N-1:0] grid, input int x, input int y);
    int   xx;
    int   yy;
    logic v;
    xx = x;
    yy = y;
    v  = 1'b0;
`ifdef LIFE_TORUS_EN
    if (xx < 0) xx = xx + GW;
    else if (xx >= GW) xx = xx - GW;
    if (yy < 0) yy = yy + GH;
    else if (yy >= GH) yy = yy - GH;
    v = grid[CW'(yy * GW + xx)];
`else
    if (xx >= 0 && xx < GW && yy >= 0 && yy < GH) v = grid[CW'(yy * GW + xx)];
`endif
    return v;
  endfunction

  assign front_c    = bank_q[front_sel_q];
  assign disp_cell  = (32'(disp_index) < N) ? front_c[CW'(disp_index)] : 1'b0;
  assign busy       = (state_q != S_IDLE);
  assign seed_ready = (state_q == S_SEED);
  assign gen_done   = gen_done_q;
  assign gen_count  = gen_count_q;

  // B3/S23 rule for the cell currently addressed by idx.
  always_comb begin
    cx_c      = int'(idx_q) % GW;
    cy_c      = int'(idx_q) / GW;
    nbr_cnt_c = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) nbr_cnt_c = nbr_cnt_c + 4'(cell_at(front_c, cx_c + dx, cy_c + dy));
      end
    end
    self_c      = front_c[CW'(idx_q)];
    next_cell_c = (nbr_cnt_c == 4'd3) || (self_c && nbr_cnt_c == 4'd2);
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    front_sel_d = front_sel_q;
    frame_cnt_d = frame_cnt_q;
    idx_d       = idx_q;
    gen_count_d = gen_count_q;
    gen_done_d  = 1'b0;
    seed_pend_d = seed_pend_q;
    trig_c      = 1'b0;

    if (seed_req && state_q != S_IDLE) seed_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        trig_c = frame_start && run && (frame_cnt_q == FCW'(PERIOD_FRAMES - 1));
        if (frame_start && run) frame_cnt_d = trig_c ? '0 : frame_cnt_q + FCW'(1);
        // A seed request wins; a coincident trigger is simply dropped.
        if (seed_req || seed_pend_q) begin
          seed_pend_d = 1'b0;
          state_d     = S_CLEAR;
        end else if (trig_c || (step && !run)) begin
          idx_d   = '0;
          state_d = S_COMPUTE;
        end
      end
      S_CLEAR: begin
        bank_d      = '0;
        front_sel_d = 1'b0;
        state_d     = S_SEED;
      end
      S_SEED: begin
        if (seed_valid) begin
          if (32'(seed_index) < N) bank_d[front_sel_q][CW'(seed_index)] = 1'b1;
          if (seed_last) begin
            gen_count_d = '0;
            frame_cnt_d = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_COMPUTE: begin
        bank_d[~front_sel_q][CW'(idx_q)] = next_cell_c;
        if (32'(idx_q) == N - 1) begin
          idx_d   = '0;
          state_d = S_SWAP_WAIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SWAP_WAIT: begin
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          gen_count_d = gen_count_q + GCW'(1);
          gen_done_d  = 1'b1;
          frame_cnt_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bank_q      <= '0;
      front_sel_q <= 1'b0;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      gen_count_q <= '0;
      gen_done_q  <= 1'b0;
      seed_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      front_sel_q <= front_sel_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      gen_count_q <= gen_count_d;
      gen_done_q  <= gen_done_d;
      seed_pend_q <= seed_pend_d;
    end
  end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler: blinker, still life, edge handling, seed handshake, races, reset.
module tb_life_gen_scheduler;

  localparam int unsigned N = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         frame_start = 1'b0;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic         seed_req = 1'b0;
  logic         seed_valid = 1'b0;
  logic [7:0]   seed_index = 8'd0;
  logic         seed_last = 1'b0;
  logic         seed_ready;
  logic [7:0]   disp_index = 8'd0;
  logic         disp_cell;
  logic         busy;
  logic         gen_done;
  logic [15:0]  gen_count;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] grid;

  always #5 clk = ~clk;

  life_gen_scheduler #(
    .GRID_W(16), .GRID_H(16), .PERIOD_FRAMES(3), .IDX_W(8)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .run(run), .step(step),
    .seed_req(seed_req), .seed_valid(seed_valid), .seed_index(seed_index),
    .seed_last(seed_last), .seed_ready(seed_ready), .disp_index(disp_index),
    .disp_cell(disp_cell), .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
  );

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic read_grid(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < int'(N); i++) begin
      disp_index = 8'(i);
      #1;
      g[i] = disp_cell;
    end
  endtask

  function automatic logic [N-1:0] grid_of(input int n, input int c [4]);
    logic [N-1:0] g;
    g = '0;
    for (int i = 0; i < n; i++) g[c[i]] = 1'b1;
    return g;
  endfunction

  task automatic seed_cells(input int n, input int c [4]);
    int guard;
    seed_req = 1'b1;
    tick(1);
    seed_req = 1'b0;
    guard = 0;
    while (!seed_ready && guard < 1000) begin
      tick(1);
      guard++;
    end
    check_eq("seed_ready_wait", N'(seed_ready), N'(1));
    for (int i = 0; i < n; i++) begin
      seed_valid = 1'b1;
      seed_index = 8'(c[i]);
      seed_last  = (i == n - 1);
      tick(1);
    end
    seed_valid = 1'b0;
    seed_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    reset = 1'b0;
    check_eq("rst_busy", N'(busy), N'(0));
    check_eq("rst_ready", N'(seed_ready), N'(0));
    check_eq("rst_done", N'(gen_done), N'(0));
    check_eq("rst_count", N'(gen_count), N'(0));
    read_grid(grid);
    check_eq("rst_grid", grid, '0);
    tick(1);

    // Blinker: compute takes exactly 256 cycles; finishing with a frame_start defers the swap
    seed_cells(3, '{84, 85, 86, 0});
    check_eq("blk0_busy", N'(busy), N'(0));
    read_grid(grid);
    check_eq("blinker_seed", grid, grid_of(3, '{84, 85, 86, 0}));
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    check_eq("blinker_busy", N'(busy), N'(1));
    tick(255);
    frame();
    check_eq("blinker_early_done", N'(gen_done), N'(0));
    check_eq("blinker_wait_busy", N'(busy), N'(1));
    tick(3);
    check_eq("blinker_hold_busy", N'(busy), N'(1));
    frame();
    check_eq("blinker_done", N'(gen_done), N'(1));
    check_eq("blinker_idle", N'(busy), N'(0));
    check_eq("blinker_count", N'(gen_count), N'(1));
    tick(1);
    check_eq("blinker_done_pulse", N'(gen_done), N'(0));
    read_grid(grid);
    check_eq("blinker_grid", grid, grid_of(3, '{69, 85, 101, 0}));
    tick(1);

    // Block still life, run=1, period 3: swaps land on frames 4 and 8
    seed_cells(4, '{17, 18, 33, 34});
    run = 1'b1;
    for (int f = 1; f <= 9; f++) begin
      frame();
      check_eq($sformatf("block_done_f%0d", f), N'(gen_done), N'(f == 4 || f == 8));
      check_eq($sformatf("block_busy_f%0d", f), N'(busy), N'(f == 3 || f == 7));
      if (f == 1) begin
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_eq("step_ignored_run", N'(busy), N'(0));
      end
      tick(299);
    end
    run = 1'b0;
    check_eq("block_count", N'(gen_count), N'(2));
    read_grid(grid);
    check_eq("block_grid", grid, grid_of(4, '{17, 18, 33, 34}));
    tick(1);

    // Edge blinker
    seed_cells(3, '{15, 0, 1, 0});
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(300);
    frame();
    check_eq("edge_done", N'(gen_done), N'(1));
    read_grid(grid);
`ifdef LIFE_TORUS_EN
    check_eq("edge_grid", grid, grid_of(3, '{240, 0, 16, 0}));
`else
    check_eq("edge_grid", grid, '0);
`endif
    tick(1);

    // Seed request during COMPUTE is held until the generation swaps
    seed_cells(3, '{84, 85, 86, 0});
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(10);
    seed_req = 1'b1;
    tick(1);
    seed_req = 1'b0;
    check_eq("pend_ready_compute", N'(seed_ready), N'(0));
    tick(300);
    check_eq("pend_ready_wait", N'(seed_ready), N'(0));
    check_eq("pend_busy_wait", N'(busy), N'(1));
    frame();
    check_eq("pend_done", N'(gen_done), N'(1));
    check_eq("pend_count", N'(gen_count), N'(1));
    check_eq("pend_idle", N'(busy), N'(0));
    tick(1);
    check_eq("pend_clear_busy", N'(busy), N'(1));
    check_eq("pend_clear_ready", N'(seed_ready), N'(0));
    tick(1);
    check_eq("pend_seed_ready", N'(seed_ready), N'(1));
    read_grid(grid);
    check_eq("pend_cleared", grid, '0);
    tick(1);
    seed_valid = 1'b1;
    seed_index = 8'd200;
    tick(2);
    seed_index = 8'd37;
    seed_last  = 1'b1;
    tick(1);
    seed_valid = 1'b0;
    seed_last  = 1'b0;
    check_eq("pend_end_busy", N'(busy), N'(0));
    check_eq("pend_end_ready", N'(seed_ready), N'(0));
    check_eq("pend_end_count", N'(gen_count), N'(0));
    read_grid(grid);
    check_eq("pend_grid", grid, grid_of(2, '{200, 37, 0, 0}));
    tick(1);

    // step together with a triggering frame_start: one generation
    seed_cells(3, '{84, 85, 86, 0});
    run = 1'b1;
    frame();
    tick(5);
    frame();
    tick(5);
    check_eq("sim_pre_busy", N'(busy), N'(0));
    frame_start = 1'b1;
    step = 1'b1;
    tick(1);
    frame_start = 1'b0;
    step = 1'b0;
    run = 1'b0;
    check_eq("sim_busy", N'(busy), N'(1));
    tick(300);
    frame();
    check_eq("sim_done", N'(gen_done), N'(1));
    frame();
    check_eq("sim_no_second", N'(gen_done), N'(0));
    check_eq("sim_count", N'(gen_count), N'(1));
    read_grid(grid);
    check_eq("sim_grid", grid, grid_of(3, '{69, 85, 101, 0}));
    tick(1);

    // seed_req together with a triggering frame_start: CLEAR wins
    run = 1'b1;
    frame();
    tick(5);
    frame();
    tick(5);
    frame_start = 1'b1;
    seed_req = 1'b1;
    tick(1);
    frame_start = 1'b0;
    seed_req = 1'b0;
    run = 1'b0;
    check_eq("sr_clear_ready", N'(seed_ready), N'(0));
    tick(1);
    check_eq("sr_seed_ready", N'(seed_ready), N'(1));
    seed_valid = 1'b1;
    seed_index = 8'd85;
    seed_last  = 1'b1;
    tick(1);
    seed_valid = 1'b0;
    seed_last  = 1'b0;
    check_eq("sr_count", N'(gen_count), N'(0));
    read_grid(grid);
    check_eq("sr_grid", grid, grid_of(1, '{85, 0, 0, 0}));
    tick(1);

    // Reset at idx=100 aborts the generation
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(300);
    frame();
    check_eq("rm_pre_count", N'(gen_count), N'(1));
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(100);
    reset = 1'b1;
    tick(1);
    check_eq("rm_busy", N'(busy), N'(0));
    check_eq("rm_count", N'(gen_count), N'(0));
    check_eq("rm_done", N'(gen_done), N'(0));
    check_eq("rm_ready", N'(seed_ready), N'(0));
    read_grid(grid);
    check_eq("rm_grid", grid, '0);
    reset = 1'b0;
    tick(1);
    frame();
    check_eq("rm_no_done", N'(gen_done), N'(0));
    check_eq("rm_idle", N'(busy), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_gen_scheduler.md
Name: life_gen_scheduler

Overview:
- Owns the Game of Life cell grid as two register banks, front and back, and sequences generation updates.
- The display path reads the front bank at any time. The update engine walks the front bank one cell per clock and writes next states into the back bank.
- Bank swap happens only on a frame boundary (vertical blank), so no frame shows a partly updated grid.
- A seed-load handshake clears the grid and loads an initial pattern. Sits between hvsync_generator frame timing and the pixel colour logic.

Parameters:
- GRID_W, 16, grid width in cells.
- GRID_H, 16, grid height in cells. N = GRID_W*GRID_H. Index = y*GRID_W + x.
- PERIOD_FRAMES, 60, frames per generation while running (range 1..255).
- IDX_W, 8, cell index width. Must satisfy 2^IDX_W >= N.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- run  in  1  level; 1 = auto-advance every PERIOD_FRAMES frames.
- step  in  1  pulse; request one generation when run=0.
- seed_req  in  1  pulse; clear both banks and enter seed load.
- seed_valid  in  1  seed cell index valid.
- seed_index  in  IDX_W  cell to set alive.
- seed_last  in  1  marks final seed beat.
- seed_ready  out  1  scheduler accepting seed beats.
- disp_index  in  IDX_W  cell index from display path.
- disp_cell  out  1  front-bank value at disp_index (combinational).
- busy  out  1  high in any state other than IDLE.
- gen_done  out  1  one-cycle pulse when a swap commits.
- gen_count  out  16  generations since last seed or reset.

Behaviour:
- Reset (sync, active-high, takes priority over everything):
  - state=IDLE; both banks=0; front select=0; frame_cnt=0; idx=0.
  - gen_count=0; seed_ready=0; busy=0; gen_done=0; pending seed=0.
  - disp_cell reads 0.
  - Reset mid-COMPUTE or mid-SEED aborts with no partial swap.
- Rule: B3/S23.
  - Dead cell with exactly 3 live neighbours → alive.
  - Live cell with 2 or 3 live neighbours → alive.
  - Otherwise → dead.
  - Neighbour count is 4 bits, max 8.
- States: IDLE, CLEAR, SEED, COMPUTE, SWAP_WAIT.
- IDLE:
  - Each frame_start with run=1 increments frame_cnt. frame_start with run=0 leaves frame_cnt unchanged.
  - Trigger when frame_start arrives with run=1 and frame_cnt==PERIOD_FRAMES-1: frame_cnt←0, go to COMPUTE.
  - step with run=0 also goes to COMPUTE. step with run=1 is ignored.
  - step and the frame trigger in the same cycle start one generation only.
  - seed_req (or a pending seed) goes to CLEAR. Seed wins over a same-cycle trigger; the dropped trigger is not retried.
- COMPUTE:
  - idx runs 0..N-1, one cell per clk: back[idx] ← rule(front neighbourhood of idx).
  - Exactly N cycles. After idx==N-1 is written, go to SWAP_WAIT.
  - frame_start pulses during COMPUTE do not advance frame_cnt.
- SWAP_WAIT:
  - On the next frame_start: toggle front select, gen_count++ (wraps 0xFFFF→0), one-cycle gen_done pulse, frame_cnt←0, go to IDLE.
  - If compute finishes in the same cycle as a frame_start, the swap waits for the following frame_start.
- seed_req outside IDLE: latched as pending. Serviced on the next IDLE cycle; the in-flight generation completes first.
- CLEAR: one cycle. Zero both banks, front select←0, go to SEED.
- SEED:
  - seed_ready=1.
  - Each beat with seed_valid & seed_ready sets front[seed_index]=1. seed_index >= N is ignored, with no error.
  - A beat with seed_last: gen_count←0, frame_cnt←0, go to IDLE. seed_ready drops in the following cycle.
  - Duplicate indices are harmless.
- disp_cell: combinational read of the front bank. Stable for a whole frame because front changes only at frame_start.
- Latency from trigger to visible new generation: N cycles plus wait until the next frame_start.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: grid edges wrap, so x-1 at x=0 reads x=GRID_W-1, and likewise for y.
- Undefined: off-grid neighbours count as dead.
- No port or timing difference between the two builds.

Test Plan:
- Blinker:
  - Stimulus: seed cells 84, 85, 86; run=0; one step; then one frame_start.
  - Response: front = {69, 85, 101} only; gen_done one pulse; gen_count=1; busy high for exactly 256 cycles in COMPUTE, then held in SWAP_WAIT until frame_start.
- Block still-life:
  - Stimulus: seed 17, 18, 33, 34; run=1, PERIOD_FRAMES=3; 9 frame_starts.
  - Response: grid unchanged; gen_done every 3rd-4th frame per the trigger/swap rule; gen_count increments each swap.
- Edge blinker:
  - Stimulus: seed 15, 0, 1; one step plus frame_start.
  - Response without LIFE_TORUS_EN: grid empty.
  - Response with LIFE_TORUS_EN: front = {240, 0, 16}.
- Seed handshake:
  - Stimulus: seed_req during COMPUTE.
  - Response: the generation completes and swaps; then CLEAR, then seed_ready=1. Beats with seed_index=300 (IDX_W=9 build) are ignored. seed_last returns to IDLE with gen_count=0.
- Simultaneous events:
  - Stimulus: step and triggering frame_start in the same cycle.
  - Response: exactly one generation and one gen_done.
  - Stimulus: seed_req plus trigger in the same cycle.
  - Response: CLEAR entered; no compute.
- Reset mid-COMPUTE:
  - Stimulus: assert reset at idx=100.
  - Response: next cycle all outputs at reset values, both banks zero, no gen_done.
